// File: rtl/ray_dispatcher_pkg.sv
// Purpose: shared widths, dir field layout, FSM state encodings and the dir
//          packing helper for the ray dispatcher.
package ray_dispatcher_pkg;

  localparam int unsigned DIR_W   = 31;
  localparam int unsigned COLOR_W = 12;
  localparam int unsigned SCENE_W = 128;
  localparam int unsigned CAM_W   = 28;
  localparam int unsigned OFF_W   = 11;  // signed h/v offset field width
  localparam int unsigned DEPTH_W = 9;
  localparam int unsigned COORD_W = 10;  // x/y range up to 1023

  // dir = {h_off, v_off, depth}
  localparam int unsigned DIR_H_LSB = 20;
  localparam int unsigned DIR_V_LSB = 9;
  localparam int unsigned DIR_D_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [OFF_W-1:0]   h_off;
    logic [OFF_W-1:0]   v_off;
    logic [DEPTH_W-1:0] depth;
  } dir_t;

  // Screen-centred ray direction for pixel (x, y); offsets wrap to 11 bits.
  function automatic dir_t make_dir(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input int unsigned        h_res,
                                    input int unsigned        v_res,
                                    input logic [DEPTH_W-1:0] focal);
    dir_t d;
    d.h_off = OFF_W'(x) - OFF_W'(h_res / 2);
    d.v_off = OFF_W'(v_res / 2) - OFF_W'(y);
    d.depth = focal;
    return d;
  endfunction

endpackage

// File: rtl/ray_dispatcher_if.sv
// Purpose: bundle of the dispatcher's control, tracer and frame-buffer signals.
//   master : dispatcher side (drives in_bus/init/dir, fb_*, busy, frame_done)
//   slave  : environment side (drives start/cont/scene_in/cam_in, dout/collision)
interface ray_dispatcher_if #(
  parameter int unsigned ADDR_W = 19
);
  import ray_dispatcher_pkg::*;

  logic               start;
  logic               cont;
  logic [SCENE_W-1:0] scene_in;
  logic [CAM_W-1:0]   cam_in;
  logic [SCENE_W-1:0] in_bus;
  logic [CAM_W-1:0]   init;
  logic [DIR_W-1:0]   dir;
  logic [COLOR_W-1:0] dout;
  logic               collision;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               busy;
  logic               frame_done;

  modport master (
    input  start, cont, scene_in, cam_in, dout, collision,
    output in_bus, init, dir, fb_we, fb_addr, fb_data, busy, frame_done
  );

  modport slave (
    output start, cont, scene_in, cam_in, dout, collision,
    input  in_bus, init, dir, fb_we, fb_addr, fb_data, busy, frame_done
  );

endinterface

// File: rtl/ray_dispatcher_pixel_scan_counter.sv
// Purpose: raster scan position for the dispatcher.
//   clk, rst          : clock, async active-high reset
//   clear_i           : return to pixel (0,0), address 0
//   advance_i         : step to next pixel in raster order
//   x_o, y_o          : current pixel coordinates
//   addr_o            : linear address y*H_RES+x, tracked incrementally
//   last_pixel_c_o    : current pixel is the bottom-right one (combinational)
module pixel_scan_counter
  import ray_dispatcher_pkg::*;
#(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               last_pixel_c_o
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               x_end;

  assign x_end          = (x_q == COORD_W'(H_RES - 1));
  assign last_pixel_c_o = x_end && (y_q == COORD_W'(V_RES - 1));

  // Next position: clear wins over advance.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (advance_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_end) begin
        x_d = '0;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/ray_dispatcher.sv
// Purpose: sweeps the pixel grid, issues one ray per pixel to the tracer,
//          waits the tracer latency and writes the resulting colour to the
//          frame buffer.
//   clk, rst : clock, async active-high reset
//   disp_if  : master modport -- start/cont/scene_in/cam_in control inputs,
//              in_bus/init/dir to the tracer, dout/collision from it,
//              fb_we/fb_addr/fb_data to the frame buffer, busy/frame_done.
// All outputs are registered decodes of the current state, so each appears
// one cycle after the state that produces it.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int unsigned        H_RES     = 640,
  parameter int unsigned        V_RES     = 480,
  parameter int unsigned        ADDR_W    = 19,
  parameter int unsigned        TRACE_LAT = 8,
  parameter logic [DEPTH_W-1:0] FOCAL     = 9'd256,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000
) (
  input logic              clk,
  input logic              rst,
  ray_dispatcher_if.master disp_if
);

  localparam int unsigned CNT_W = (TRACE_LAT > 1) ? $clog2(TRACE_LAT) : 1;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SCENE_W-1:0] in_bus_q, in_bus_d;
  logic [CAM_W-1:0]   init_q, init_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_data_q, fb_data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               scan_clear, scan_adv, last_pixel;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic [ADDR_W-1:0]  scan_addr;

  pixel_scan_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (scan_clear),
    .advance_i      (scan_adv),
    .x_o            (scan_x),
    .y_o            (scan_y),
    .addr_o         (scan_addr),
    .last_pixel_c_o (last_pixel)
  );

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the latency counter restarts on every ISSUE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (disp_if.start) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(TRACE_LAT - 1)) state_d = ST_WRITE;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WRITE: state_d = last_pixel ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_d = disp_if.cont ? ST_LATCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next-values: data outputs hold unless their state loads them.
  always_comb begin
    in_bus_d     = in_bus_q;
    init_d       = init_q;
    dir_d        = dir_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    scan_clear   = 1'b0;
    scan_adv     = 1'b0;
    case (state_q)
      ST_LATCH: begin
        in_bus_d   = disp_if.scene_in;
        init_d     = disp_if.cam_in;
        scan_clear = 1'b1;
        busy_d     = 1'b1;
      end
      ST_ISSUE: begin
        dir_d  = DIR_W'(make_dir(scan_x, scan_y, H_RES, V_RES, FOCAL));
        busy_d = 1'b1;
      end
      ST_WAIT: busy_d = 1'b1;
      ST_WRITE: begin
        fb_we_d   = 1'b1;
        fb_addr_d = scan_addr;
        fb_data_d = disp_if.collision ? disp_if.dout : BG_COLOR;
        // Hold position on the last pixel; LATCH clears it next frame.
        scan_adv  = !last_pixel;
        busy_d    = 1'b1;
      end
      ST_DONE: frame_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_bus_q     <= '0;
      init_q       <= '0;
      dir_q        <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_bus_q     <= in_bus_d;
      init_q       <= init_d;
      dir_q        <= dir_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp_if.in_bus     = in_bus_q;
  assign disp_if.init       = init_q;
  assign disp_if.dir        = dir_q;
  assign disp_if.fb_we      = fb_we_q;
  assign disp_if.fb_addr    = fb_addr_q;
  assign disp_if.fb_data    = fb_data_q;
  assign disp_if.busy       = busy_q;
  assign disp_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 screen with a 3-stage tracer model.
module tb_ray_dispatcher;

  localparam logic [127:0] SCENE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] SCENE_B = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
  localparam logic [27:0]  CAM_A   = 28'hA5A5A5A;
  localparam logic [27:0]  CAM_B   = 28'h1234567;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hit_color;
  logic        odd_miss;
  logic [30:0] d1, d2, d3;
  int          n_tests = 0;
  int          n_fail  = 0;

  ray_dispatcher_if #(.ADDR_W(3)) dif ();

  ray_dispatcher #(
    .H_RES     (4),
    .V_RES     (2),
    .ADDR_W    (3),
    .TRACE_LAT (3),
    .FOCAL     (9'd256),
    .BG_COLOR  (12'h00F)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_if (dif.master)
  );

  always #5 clk = ~clk;

  // Tracer model: dir through a 3-register delay line. Odd pixel addresses
  // have odd x (H_RES even), i.e. odd h_off, so bit 20 of dir marks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d1 <= dif.dir;
      d2 <= d1;
      d3 <= d2;
    end
  end
  assign dif.dout      = hit_color;
  assign dif.collision = !(odd_miss && d3[20]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] exp_dir(input int p);
    logic [10:0] h, v;
    h = 11'(p % 4) - 11'd2;
    v = 11'd1 - 11'(p / 4);
    return {h, v, 9'h100};
  endfunction

  // Call right after the edge that samples start (edge 0); checks edges 1..42.
  task automatic run_frame(input logic [127:0] exp_scene, input logic [27:0] exp_cam,
                           input bit disturb, input int abort_k);
    logic        exp_we;
    logic [11:0] exp_data;
    int          p;
    for (int k = 1; k <= 42; k++) begin
      tick();
      exp_we = (k >= 6) && (k <= 41) && ((k - 6) % 5 == 0);
      chk($sformatf("busy k=%0d", k), 128'(dif.busy), 128'(k <= 41));
      chk($sformatf("fb_we k=%0d", k), 128'(dif.fb_we), 128'(exp_we));
      chk($sformatf("frame_done k=%0d", k), 128'(dif.frame_done), 128'(k == 42));
      if (exp_we) begin
        p = (k - 6) / 5;
        exp_data = (odd_miss && (p % 2 == 1)) ? 12'h00F : hit_color;
        chk($sformatf("fb_addr k=%0d", k), 128'(dif.fb_addr), 128'(p));
        chk($sformatf("fb_data k=%0d", k), 128'(dif.fb_data), 128'(exp_data));
      end
      if ((k >= 2) && (k <= 37) && ((k - 2) % 5 == 0))
        chk($sformatf("dir k=%0d", k), 128'(dif.dir), 128'(exp_dir((k - 2) / 5)));
      if (k == 2)  chk("dir pixel(0,0)", 128'(dif.dir), 128'({11'h7FE, 11'h001, 9'h100}));
      if (k == 37) chk("dir pixel(3,1)", 128'(dif.dir), 128'({11'h001, 11'h000, 9'h100}));
      if (k == 20) begin
        chk("in_bus held", dif.in_bus, exp_scene);
        chk("init held", 128'(dif.init), 128'(exp_cam));
      end
      if (disturb) begin
        if (k == 10) begin
          dif.scene_in = SCENE_B;
          dif.cam_in   = CAM_B;
          dif.start    = 1'b1;
        end
        if (k == 11) dif.start = 1'b0;
        if (k == 30) dif.cont  = 1'b1;
      end
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        chk("abort fb_we", 128'(dif.fb_we), 128'(0));
        chk("abort busy", 128'(dif.busy), 128'(0));
        chk("abort fb_addr", 128'(dif.fb_addr), 128'(0));
        #2;
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    chk("busy at start edge", 128'(dif.busy), 128'(0));
  endtask

  initial begin
    rst          = 1'b1;
    hit_color    = 12'hABC;
    odd_miss     = 1'b0;
    dif.start    = 1'b0;
    dif.cont     = 1'b0;
    dif.scene_in = SCENE_A;
    dif.cam_in   = CAM_A;
    tick();
    tick();
    chk("reset busy", 128'(dif.busy), 128'(0));
    chk("reset fb_we", 128'(dif.fb_we), 128'(0));
    chk("reset dir", 128'(dif.dir), 128'(0));
    chk("reset in_bus", dif.in_bus, 128'(0));
    chk("reset frame_done", 128'(dif.frame_done), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle fb_we", 128'(dif.fb_we), 128'(0));
      chk("idle busy", 128'(dif.busy), 128'(0));
    end

    // Frame 1: all hits, colour ABC.
    pulse_start();
    run_frame(SCENE_A, CAM_A, 1'b0, 0);

    // Async reset mid-cycle clears every output before any clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("async in_bus", dif.in_bus, 128'(0));
    chk("async init", 128'(dif.init), 128'(0));
    chk("async dir", 128'(dif.dir), 128'(0));
    chk("async fb_addr", 128'(dif.fb_addr), 128'(0));
    chk("async fb_data", 128'(dif.fb_data), 128'(0));
    chk("async fb_we", 128'(dif.fb_we), 128'(0));
    chk("async busy", 128'(dif.busy), 128'(0));
    chk("async frame_done", 128'(dif.frame_done), 128'(0));
    #1;
    rst = 1'b0;

    // Frame 2: misses on odd addresses give background colour.
    odd_miss = 1'b1;
    pulse_start();
    run_frame(SCENE_A, CAM_A, 1'b0, 0);
    odd_miss = 1'b0;

    // Frame 3: scene change + start mid-frame, cont raised; frame 4 relatches.
    hit_color = 12'h5A3;
    pulse_start();
    run_frame(SCENE_A, CAM_A, 1'b1, 0);
    dif.cont = 1'b0;
    run_frame(SCENE_B, CAM_B, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post idle busy", 128'(dif.busy), 128'(0));
      chk("post idle fb_we", 128'(dif.fb_we), 128'(0));
      chk("post idle frame_done", 128'(dif.frame_done), 128'(0));
    end

    // Frame 5: reset during WAIT of pixel 5, then a clean frame from addr 0.
    pulse_start();
    run_frame(SCENE_B, CAM_B, 1'b0, 28);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("after abort fb_we", 128'(dif.fb_we), 128'(0));
    end
    pulse_start();
    run_frame(SCENE_B, CAM_B, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
